// File: rtl/itrx_amba2_apb_master_pkg.sv
// ============================================================================
// itrx_amba2_apb_master_pkg : shared APB direction and master FSM state types
// Rev 1.0
// ============================================================================
`default_nettype none

package itrx_amba2_apb_master_pkg;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } te_pwrite;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ENABLE = 2'd2
  } te_apb_state;

endpackage

`default_nettype wire

// File: rtl/itrx_amba2_apb_master_if.sv
// ============================================================================
// itrx_amba2_apb_master_if : request/response queue side plus AMBA2 APB bus
// Rev 1.0
// ============================================================================
`default_nettype none

interface itrx_amba2_apb_master_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic          rsp_write;
  logic [DW-1:0] rsp_rdata;
  logic          busy;
  logic [AW-1:0] paddr;
  logic          psel;
  logic          penable;
  logic          pwrite;
  logic [DW-1:0] pwdata;
  logic [DW-1:0] prdata;

  // The bridge itself: consumes requests, masters the APB bus
  modport master (
    input  req_valid, req_write, req_addr, req_wdata, prdata,
    output req_ready, rsp_valid, rsp_write, rsp_rdata, busy,
    output paddr, psel, penable, pwrite, pwdata
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, prdata,
    input  req_ready, rsp_valid, rsp_write, rsp_rdata, busy,
    input  paddr, psel, penable, pwrite, pwdata
  );
endinterface

`default_nettype wire

// File: rtl/itrx_sync_fifo.sv
// ============================================================================
// itrx_sync_fifo : show-ahead synchronous FIFO, power-of-2 depth
// Rev 1.0
// ============================================================================
`default_nettype none

module itrx_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             i_push,
  input  wire logic [WIDTH-1:0] i_data,
  input  wire logic             i_pop,
  output logic      [WIDTH-1:0] o_data,
  output logic                  o_full,
  output logic                  o_empty
);
  localparam int            c_PW      = $clog2(DEPTH);
  localparam logic [c_PW:0] c_PTR_ONE = (c_PW + 1)'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_PW:0]    r_wptr;
  logic [c_PW:0]    r_rptr;
  logic             w_push;
  logic             w_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match
  assign o_full  = (r_wptr[c_PW] != r_rptr[c_PW]) &&
                   (r_wptr[c_PW-1:0] == r_rptr[c_PW-1:0]);
  assign o_empty = (r_wptr == r_rptr);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_data  = r_mem[r_rptr[c_PW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + c_PTR_ONE;
      if (w_pop)  r_rptr <= r_rptr + c_PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[c_PW-1:0]] <= i_data;
  end

endmodule

`default_nettype wire

// File: rtl/itrx_amba2_apb_master.sv
// ============================================================================
// itrx_amba2_apb_master : queued request to AMBA2 APB master bridge
// Rev 1.0
// ============================================================================
`default_nettype none

module itrx_amba2_apb_master
  import itrx_amba2_apb_master_pkg::*;
#(
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int DEPTH = 4
) (
  input wire logic                clk,
  input wire logic                rst,
  itrx_amba2_apb_master_if.master bus
);
  typedef struct packed {
    te_pwrite      write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } ts_apb_req;

  localparam int c_REQ_W = $bits(ts_apb_req);

  ts_apb_req          w_push_req;
  ts_apb_req          w_head;
  logic [c_REQ_W-1:0] w_head_bits;
  logic               w_full;
  logic               w_empty;
  logic               w_pop;

  te_apb_state        r_state;
  logic [AW-1:0]      r_paddr;
  te_pwrite           r_pwrite;
  logic [DW-1:0]      r_pwdata;
  logic               r_psel;
  logic               r_penable;
  logic               r_rsp_valid;
  te_pwrite           r_rsp_write;
  logic [DW-1:0]      r_rsp_rdata;

  assign w_push_req = '{write: te_pwrite'(bus.req_write),
                        addr:  bus.req_addr,
                        wdata: bus.req_wdata};
  assign w_head     = ts_apb_req'(w_head_bits);

  itrx_sync_fifo #(
    .WIDTH (c_REQ_W),
    .DEPTH (DEPTH)
  ) u_req_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (bus.req_valid),
    .i_data  (w_push_req),
    .i_pop   (w_pop),
    .o_data  (w_head_bits),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // The head is consumed exactly when the FSM launches a new SETUP phase
  assign w_pop = !w_empty && ((r_state == IDLE) || (r_state == ENABLE));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_paddr     <= '0;
      r_pwrite    <= READ;
      r_pwdata    <= '0;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_write <= READ;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!w_empty) begin
            r_paddr   <= w_head.addr;
            r_pwrite  <= w_head.write;
            r_pwdata  <= (w_head.write == WRITE) ? w_head.wdata : '0;
            r_psel    <= 1'b1;
            r_penable <= 1'b0;
            r_state   <= SETUP;
          end
        end
        SETUP: begin
          r_penable <= 1'b1;
          r_state   <= ENABLE;
        end
        ENABLE: begin
          r_rsp_valid <= 1'b1;
          r_rsp_write <= r_pwrite;
          r_rsp_rdata <= (r_pwrite == WRITE) ? '0 : bus.prdata;
          r_penable   <= 1'b0;
          if (!w_empty) begin
            r_paddr  <= w_head.addr;
            r_pwrite <= w_head.write;
            r_pwdata <= (w_head.write == WRITE) ? w_head.wdata : '0;
            r_state  <= SETUP;
          end else begin
            r_psel  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_psel    <= 1'b0;
          r_penable <= 1'b0;
          r_state   <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready = !w_full;
  assign bus.busy      = !w_empty || (r_state != IDLE);
  assign bus.paddr     = r_paddr;
  assign bus.pwrite    = r_pwrite;
  assign bus.pwdata    = r_pwdata;
  assign bus.psel      = r_psel;
  assign bus.penable   = r_penable;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_write = r_rsp_write;
  assign bus.rsp_rdata = r_rsp_rdata;

endmodule

`default_nettype wire

// File: tb/tb_itrx_amba2_apb_master.sv
// ============================================================================
// tb_itrx_amba2_apb_master : directed self-checking bench with APB slave model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_itrx_amba2_apb_master;
  import itrx_amba2_apb_master_pkg::*;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  itrx_amba2_apb_master_if #(.AW(AW), .DW(DW)) bus ();

  itrx_amba2_apb_master #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [DW-1:0] slave_rdata(input logic [AW-1:0] a);
    return (a == 32'h24) ? 32'h1234_5678 : {a[15:0], 16'hC0DE};
  endfunction

  // Slave drives read data only while the access is in its ENABLE phase
  assign bus.prdata = (bus.psel && bus.penable) ? slave_rdata(bus.paddr) : '0;

  int n_checks = 0;
  int n_errs   = 0;
  int n_rsp    = 0;

  logic [AW+DW:0] q_setup [$];
  logic [DW:0]    q_rsp   [$];
  logic [AW+DW:0] m_setup;
  logic [DW:0]    m_rsp;
  logic [DW-1:0]  s_wdata;
  logic [DW-1:0]  s_rdata;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s act=0x%0h exp=0x%0h", tag, act, exp);
    end
  endtask

  // Scoreboard: every accepted request yields one expected SETUP and response
  always @(posedge clk) begin
    if (!rst && bus.req_valid && bus.req_ready) begin
      s_wdata = bus.req_write ? bus.req_wdata : 32'h0;
      s_rdata = bus.req_write ? 32'h0 : slave_rdata(bus.req_addr);
      q_setup.push_back({bus.req_write, bus.req_addr, s_wdata});
      q_rsp.push_back({bus.req_write, s_rdata});
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.psel === 1'b1 && bus.penable === 1'b0) begin
        if (q_setup.size() == 0) begin
          check_eq("setup_unexpected", 1, 0);
        end else begin
          m_setup = q_setup.pop_front();
          check_eq("mon_pwrite", bus.pwrite, m_setup[AW+DW]);
          check_eq("mon_paddr",  bus.paddr,  m_setup[AW+DW-1:DW]);
          check_eq("mon_pwdata", bus.pwdata, m_setup[DW-1:0]);
        end
      end
      if (bus.rsp_valid === 1'b1) begin
        n_rsp++;
        if (q_rsp.size() == 0) begin
          check_eq("rsp_unexpected", 1, 0);
        end else begin
          m_rsp = q_rsp.pop_front();
          check_eq("mon_rsp_write", bus.rsp_write, m_rsp[DW]);
          check_eq("mon_rsp_rdata", bus.rsp_rdata, m_rsp[DW-1:0]);
        end
      end
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req_valid = v;
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_wdata = d;
  endtask

  // Single transfer from idle; cycle k is observed after the k-th edge from acceptance
  task automatic single(input string tag, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    drive(1'b1, w, a, d);
    cyc();
    drive(1'b0, 1'b0, '0, '0);
    check_eq({tag, "_c0_psel"}, bus.psel, 0);
    check_eq({tag, "_c0_busy"}, bus.busy, 1);
    cyc();
    check_eq({tag, "_c1_psel"},    bus.psel,    1);
    check_eq({tag, "_c1_penable"}, bus.penable, 0);
    check_eq({tag, "_c1_paddr"},   bus.paddr,   a);
    check_eq({tag, "_c1_pwrite"},  bus.pwrite,  w);
    check_eq({tag, "_c1_pwdata"},  bus.pwdata,  w ? d : 32'h0);
    cyc();
    check_eq({tag, "_c2_psel"},    bus.psel,      1);
    check_eq({tag, "_c2_penable"}, bus.penable,   1);
    check_eq({tag, "_c2_rsp"},     bus.rsp_valid, 0);
    cyc();
    check_eq({tag, "_c3_rsp"},       bus.rsp_valid, 1);
    check_eq({tag, "_c3_rsp_write"}, bus.rsp_write, w);
    check_eq({tag, "_c3_rsp_rdata"}, bus.rsp_rdata, w ? 32'h0 : slave_rdata(a));
    cyc();
    check_eq({tag, "_c4_psel"}, bus.psel,      0);
    check_eq({tag, "_c4_rsp"},  bus.rsp_valid, 0);
    check_eq({tag, "_c4_busy"}, bus.busy,      0);
  endtask

  // Streams n requests with req_valid held high; reports the accept count at the first stall
  task automatic stream(input string tag, input int n, input logic [AW-1:0] base,
                        output int acc_at_low, output logic rdy_after_low);
    int   idx  = 0;
    int   rsp0 = n_rsp;
    int   low_cyc = -1;
    logic rdy;
    acc_at_low    = -1;
    rdy_after_low = 1'b0;
    drive(1'b1, 1'b1, base, 32'hA000_0000);
    for (int t = 0; t < 400 && idx < n; t++) begin
      rdy = bus.req_ready;
      cyc();
      if (rdy) idx++;
      if (idx < n) drive(1'b1, idx[0] == 1'b0, base + AW'(idx * 4), 32'hA000_0000 | DW'(idx));
      else         drive(1'b0, 1'b0, '0, '0);
      if (low_cyc >= 0 && t == low_cyc + 1) rdy_after_low = bus.req_ready;
      if (acc_at_low < 0 && !bus.req_ready) begin
        acc_at_low = idx;
        low_cyc    = t;
      end
    end
    check_eq({tag, "_accepted"}, idx, n);
    for (int t = 0; t < 200 && (n_rsp - rsp0) < n; t++) cyc();
    repeat (4) cyc();
    check_eq({tag, "_rsp_count"}, n_rsp - rsp0, n);
    check_eq({tag, "_queue_empty"}, q_rsp.size(), 0);
    check_eq({tag, "_busy_end"}, bus.busy, 0);
  endtask

  initial begin
    int   acc_low;
    logic rdy_rec;
    int   rsp_snap;
    logic e_psel, e_pen, e_rsp;

    drive(1'b0, 1'b0, '0, '0);
    repeat (3) cyc();
    rst = 1'b0;
    check_eq("rst_req_ready", bus.req_ready, 1);
    check_eq("rst_psel",      bus.psel,      0);
    check_eq("rst_penable",   bus.penable,   0);
    check_eq("rst_rsp_valid", bus.rsp_valid, 0);
    check_eq("rst_rsp_write", bus.rsp_write, 0);
    check_eq("rst_rsp_rdata", bus.rsp_rdata, 0);
    check_eq("rst_busy",      bus.busy,      0);
    check_eq("rst_paddr",     bus.paddr,     0);
    check_eq("rst_pwrite",    bus.pwrite,    0);
    check_eq("rst_pwdata",    bus.pwdata,    0);
    cyc();

    single("wr", 1'b1, 32'h10, 32'hDEAD_BEEF);
    single("rd", 1'b0, 32'h24, 32'h5555_5555);

    // Three back-to-back requests: psel high cycles 1..6, responses at 3,5,7
    drive(1'b1, 1'b1, 32'h30, 32'h1111_1111);
    for (int c = 0; c <= 8; c++) begin
      cyc();
      if (c == 0)      drive(1'b1, 1'b0, 32'h34, 32'h0);
      else if (c == 1) drive(1'b1, 1'b1, 32'h38, 32'h3333_3333);
      else if (c == 2) drive(1'b0, 1'b0, '0, '0);
      e_psel = (c >= 1 && c <= 6);
      e_pen  = (c == 2 || c == 4 || c == 6);
      e_rsp  = (c == 3 || c == 5 || c == 7);
      check_eq($sformatf("b2b_psel_c%0d", c),    bus.psel,      e_psel);
      check_eq($sformatf("b2b_penable_c%0d", c), bus.penable,   e_pen);
      check_eq($sformatf("b2b_rsp_c%0d", c),     bus.rsp_valid, e_rsp);
    end

    stream("full", 8, 32'h100, acc_low, rdy_rec);
    check_eq("full_accepts_before_stall", acc_low, 7);
    check_eq("full_ready_recovers", rdy_rec, 1);

    stream("wrap", 20, 32'h0, acc_low, rdy_rec);

    // Reset during ENABLE of the second of four transfers
    drive(1'b1, 1'b1, 32'h200, 32'h2000_0000);
    cyc(); drive(1'b1, 1'b1, 32'h204, 32'h2000_0001);
    cyc(); drive(1'b1, 1'b1, 32'h208, 32'h2000_0002);
    cyc(); drive(1'b1, 1'b1, 32'h20C, 32'h2000_0003);
    cyc(); drive(1'b0, 1'b0, '0, '0);
    cyc();
    check_eq("rstmid_enable_psel",    bus.psel,    1);
    check_eq("rstmid_enable_penable", bus.penable, 1);
    check_eq("rstmid_enable_paddr",   bus.paddr,   32'h204);
    rst = 1'b1;
    q_setup.delete();
    q_rsp.delete();
    rsp_snap = n_rsp;
    cyc();
    rst = 1'b0;
    check_eq("rstmid_psel",      bus.psel,      0);
    check_eq("rstmid_penable",   bus.penable,   0);
    check_eq("rstmid_req_ready", bus.req_ready, 1);
    check_eq("rstmid_busy",      bus.busy,      0);
    check_eq("rstmid_rsp_valid", bus.rsp_valid, 0);
    repeat (8) cyc();
    check_eq("rstmid_no_rsp", n_rsp, rsp_snap);
    check_eq("rstmid_no_psel", bus.psel, 0);
    single("post_rst", 1'b0, 32'h40, 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
